// File: rtl/ahbl_sram_slave_if.sv
// ----------------------------------------------------------------------------
// ahbl_sram_slave_if
//
// Purpose:
//   Groups the AHB-Lite signals exchanged between a bus master (or the bus
//   fabric) and the ahbl_sram_slave memory. HCLK and HRESETN are not part of
//   this bundle; they stay plain module ports.
//
// Signals:
//   HSEL      slave select
//   HADDR     byte address (address phase)
//   HTRANS    transfer type; only HTRANS[1] (NONSEQ/SEQ) starts a transfer
//   HWRITE    1 = write, 0 = read
//   HSIZE     0 = byte, 1 = halfword, 2 = word
//   HWDATA    write data (data phase)
//   HREADYIN  bus-level HREADY seen by the slave
//   HREADYOUT slave ready
//   HRDATA    read data
//   HRESP     0 = OKAY, 1 = ERROR
//
// Modports:
//   master  drives the request side, observes the response side
//   slave   observes the request side, drives the response side
// ----------------------------------------------------------------------------
interface ahbl_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYIN;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahbl_sram_slave.sv
// ----------------------------------------------------------------------------
// ahbl_sram_slave
//
// Purpose:
//   AHB-Lite slave SRAM with a fixed number of inserted wait states, a
//   read-only region at the top of memory and the standard two-cycle ERROR
//   response. Supports single byte / halfword / word transfers with
//   little-endian byte lanes. HADDR bits above MEM_AWIDTH are ignored, so
//   the memory aliases across the address space.
//
// Parameters:
//   MEM_AWIDTH   byte-address bits decoded; depth is 2^(MEM_AWIDTH-2) words
//   WAIT_STATES  HREADYOUT-low cycles in every OKAY data phase (0..15)
//   RO_WORDS     number of read-only words at the top of memory
//
// Ports:
//   HCLK     bus clock, all state updates on its rising edge
//   HRESETN  asynchronous active-low reset
//   bus      ahbl_sram_slave_if.slave: request in, HREADYOUT/HRDATA/HRESP out
// ----------------------------------------------------------------------------
module ahbl_sram_slave #(
    parameter int MEM_AWIDTH  = 12,
    parameter int WAIT_STATES = 0,
    parameter int RO_WORDS    = 0
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    ahbl_sram_slave_if.slave   bus
);

    localparam int IDX_W = MEM_AWIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;

    // First read-only word index; one extra bit so RO_WORDS=0 gives DEPTH,
    // which no real index can reach.
    localparam logic [IDX_W:0] RO_BASE = (IDX_W + 1)'(DEPTH - RO_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state_q,   state_d;
    logic [3:0]       waitCnt_q, waitCnt_d;
    logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
    logic [3:0]       byteEn_q,  byteEn_d;
    logic             write_q,   write_d;
    logic             pending_q, pending_d;

    logic [31:0]      mem_q [DEPTH];

    logic             selfReady;
    logic             accept;
    logic [IDX_W-1:0] reqIdx;
    logic [3:0]       reqBe;
    logic             reqErr;
    logic             memWe;
    logic             readyOut;
    logic             respOut;
    logic [31:0]      rdataOut;
    logic             unusedBits;

    // Address bits above the decoded range and HTRANS[0] (NONSEQ vs SEQ)
    // do not influence this slave.
    assign unusedBits = ^{bus.HADDR[31:MEM_AWIDTH], bus.HTRANS[0]};

    // A new address phase can only be taken while this slave is not stalling
    // the bus. With a single slave HREADYIN already follows HREADYOUT, but the
    // extra term keeps a misbehaving fabric from restarting a transfer that
    // is still in its WAIT or ERR1 cycle.
    assign selfReady = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign accept    = bus.HSEL && bus.HTRANS[1] && bus.HREADYIN && selfReady;
    assign reqIdx    = bus.HADDR[MEM_AWIDTH-1:2];

    // Address-phase decode: byte-lane enables and the error conditions.
    // Everything here is captured on accept so the data phase needs nothing
    // from the address bus.
    always_comb begin
        reqBe = 4'b1111;
        case (bus.HSIZE)
            3'd0:    reqBe = 4'b0001 << bus.HADDR[1:0];
            3'd1:    reqBe = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: reqBe = 4'b1111;
        endcase

        reqErr = 1'b0;
        if (bus.HSIZE > 3'd2) begin
            reqErr = 1'b1;
        end
        if ((bus.HSIZE == 3'd1) && bus.HADDR[0]) begin
            reqErr = 1'b1;
        end
        if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) begin
            reqErr = 1'b1;
        end
        if (bus.HWRITE && ({1'b0, reqIdx} >= RO_BASE)) begin
            reqErr = 1'b1;
        end
    end

    // Next-state logic. IDLE, DATA and ERR2 all present HREADYOUT=1, so they
    // share one launch path: a new accept there starts the next transfer,
    // otherwise the slave falls back to IDLE.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        wordIdx_d = wordIdx_q;
        byteEn_d  = byteEn_q;
        write_d   = write_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
                if (accept) begin
                    wordIdx_d = reqIdx;
                    byteEn_d  = reqBe;
                    write_d   = bus.HWRITE;
                    if (reqErr) begin
                        state_d = ST_ERR1;
                    end else begin
                        pending_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            state_d   = ST_WAIT;
                            waitCnt_d = 4'(WAIT_STATES);
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end

            // Counter is loaded with WAIT_STATES, so leaving at 1 gives
            // exactly WAIT_STATES low cycles.
            ST_WAIT: begin
                waitCnt_d = waitCnt_q - 4'd1;
                if (waitCnt_q == 4'd1) begin
                    state_d = ST_DATA;
                end
            end

            ST_ERR1: begin
                state_d = ST_ERR2;
            end

            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // Control registers. Reset drops any transfer in flight, including a
    // write still waiting out its stall.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= ST_IDLE;
            waitCnt_q <= '0;
            wordIdx_q <= '0;
            byteEn_q  <= '0;
            write_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            wordIdx_q <= wordIdx_d;
            byteEn_q  <= byteEn_d;
            write_q   <= write_d;
            pending_q <= pending_d;
        end
    end

    // Write completes at the edge that closes the DATA cycle, when HWDATA is
    // valid. Memory contents are deliberately not reset.
    assign memWe = (state_q == ST_DATA) && write_q && pending_q;

    always_ff @(posedge HCLK) begin
        if (memWe) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn_q[b]) begin
                    mem_q[wordIdx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Response outputs are pure functions of the state. Read data comes
    // combinationally from the registered index, so a read right after a
    // write to the same word already sees the new contents.
    always_comb begin
        readyOut = 1'b1;
        respOut  = 1'b0;
        rdataOut = '0;
        case (state_q)
            ST_WAIT: begin
                readyOut = 1'b0;
            end
            ST_DATA: begin
                if (!write_q && pending_q) begin
                    rdataOut = mem_q[wordIdx_q];
                end
            end
            ST_ERR1: begin
                readyOut = 1'b0;
                respOut  = 1'b1;
            end
            ST_ERR2: begin
                respOut = 1'b1;
            end
            default: begin
                readyOut = 1'b1;
            end
        endcase
    end

    assign bus.HREADYOUT = readyOut;
    assign bus.HRESP     = respOut;
    assign bus.HRDATA    = rdataOut;

endmodule
